// File: rtl/br_svc_fifo_pkg.sv
// BrLite service FIFO payload types shared by the design and its bench.
package br_svc_fifo_pkg;

  // Packet as delivered by the BrLite router.
  typedef struct packed {
    logic [1:0]  service;
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] seq_target;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_out_t;

  // Entry kept in the queue and presented to the NI.
  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;

endpackage

// File: rtl/br_svc_fifo.sv
// Service queue between the BrLite router and the NI: stores ALL/TARGET
// packets in arrival order and consumes MONITOR/CLEAR packets without storing.
module br_svc_fifo
  import br_svc_fifo_pkg::*;
#(
  parameter int unsigned BR_SVC_DEPTH = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              br_req_i,
  output logic                              br_ack_o,
  input  brlite_out_t                       br_data_i,
  output logic                              br_svc_rx_o,
  input  logic                              br_svc_ack_i,
  output brlite_svc_t                       br_svc_data_o,
  output logic [$clog2(BR_SVC_DEPTH):0]     br_svc_count_o,
  output logic                              br_mon_drop_o
);

  localparam int unsigned PTR_W = $clog2(BR_SVC_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ack_q, ack_d;
  logic             drop_q, drop_d;

  brlite_svc_t      mem_q [BR_SVC_DEPTH];
  brlite_svc_t      wdata_c;

  logic             storable_c;
  logic             full_c;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;

  // Fields the queue does not keep; named so that lint treats them as intentionally unused.
  logic             unused_fields;
  assign unused_fields = ^{br_data_i.service[0], br_data_i.seq_target};

  // Accept/push/pop decisions and next-state, all from registered state (no full bypass).
  always_comb begin
    storable_c = 1'b0;
    full_c     = 1'b0;
    accept_c   = 1'b0;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ack_d      = 1'b0;
    drop_d     = 1'b0;
    wdata_c    = '{ksvc:       br_data_i.ksvc,
                   seq_source: br_data_i.seq_source,
                   producer:   br_data_i.producer,
                   payload:    br_data_i.payload};

    storable_c = ~br_data_i.service[1];
    full_c     = (count_q == CNT_W'(BR_SVC_DEPTH));
    accept_c   = br_req_i & ~ack_q & (~storable_c | ~full_c);
    push_c     = accept_c & storable_c;
    pop_c      = br_svc_ack_i & (count_q != '0);

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end

    ack_d  = accept_c;
    drop_d = accept_c & ~storable_c;
  end

  // Pointer, occupancy and handshake registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents survive reset and are only meaningful while non-empty.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wdata_c;
    end
  end

  assign br_ack_o       = ack_q;
  assign br_mon_drop_o  = drop_q;
  assign br_svc_count_o = count_q;
  assign br_svc_rx_o    = (count_q != '0);
  assign br_svc_data_o  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_br_svc_fifo.sv
// Self-checking bench for br_svc_fifo: directed table, corner sequences, random vs queue model.
module tb_br_svc_fifo;
  import br_svc_fifo_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk_i;
  logic          rst_ni;
  logic          br_req_i;
  logic          br_ack_o;
  brlite_out_t   br_data_i;
  logic          br_svc_rx_o;
  logic          br_svc_ack_i;
  brlite_svc_t   br_svc_data_o;
  logic [CW-1:0] br_svc_count_o;
  logic          br_mon_drop_o;

  int n_chk;
  int n_fail;

  br_svc_fifo #(.BR_SVC_DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .br_req_i       (br_req_i),
    .br_ack_o       (br_ack_o),
    .br_data_i      (br_data_i),
    .br_svc_rx_o    (br_svc_rx_o),
    .br_svc_ack_i   (br_svc_ack_i),
    .br_svc_data_o  (br_svc_data_o),
    .br_svc_count_o (br_svc_count_o),
    .br_mon_drop_o  (br_mon_drop_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        req;
    brlite_out_t pkt;
    logic        pop;
    logic        e_ack;
    logic        e_drop;
    int          e_cnt;
    brlite_svc_t e_data;
  } vec_t;

  function automatic brlite_out_t mk(input logic [1:0] svc, input logic [7:0] k,
                                     input logic [15:0] src, input logic [15:0] tgt,
                                     input logic [15:0] prod, input logic [31:0] pay);
    brlite_out_t p;
    p.service = svc; p.ksvc = k; p.seq_source = src; p.seq_target = tgt;
    p.producer = prod; p.payload = pay;
    return p;
  endfunction

  function automatic brlite_svc_t to_svc(input brlite_out_t p);
    brlite_svc_t s;
    s.ksvc = p.ksvc; s.seq_source = p.seq_source; s.producer = p.producer; s.payload = p.payload;
    return s;
  endfunction

  function automatic brlite_out_t rnd_pkt();
    logic [1:0] svc;
    svc = ($urandom_range(0, 4) == 0) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
    return mk(svc, 8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 32'($urandom));
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    br_req_i     = 1'b0;
    br_svc_ack_i = 1'b0;
    br_data_i    = '0;
    rst_ni       = 1'b0;
    #2;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Present one packet, expect acceptance on the next edge, then drop the request.
  task automatic push(input brlite_out_t p);
    br_req_i  = 1'b1;
    br_data_i = p;
    tick();
    chk("push_ack", 96'(br_ack_o), 96'(1'b1));
    br_req_i = 1'b0;
    tick();
  endtask

  // Check head against expectation, then pop it.
  task automatic pop_chk(input string nm, input brlite_svc_t e);
    chk({nm, "_rx"}, 96'(br_svc_rx_o), 96'(1'b1));
    chk({nm, "_data"}, 96'(br_svc_data_o), 96'(e));
    br_svc_ack_i = 1'b1;
    tick();
    br_svc_ack_i = 1'b0;
  endtask

  vec_t        tbl[12];
  brlite_out_t pa, pb, pc, pm, pcl;
  brlite_out_t p9[9];
  brlite_out_t pw[20];
  brlite_svc_t mq[$];
  logic        m_ack, m_drop, acc, pp;
  logic        r_req;
  brlite_out_t r_pkt;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_ni = 1'b1;
    br_req_i = 1'b0;
    br_svc_ack_i = 1'b0;
    br_data_i = '0;

    pa  = mk(2'b01, 8'h2A, 16'h0102, 16'h0000, 16'h0304, 32'hDEADBEEF);
    pb  = mk(2'b00, 8'h11, 16'h1111, 16'h2222, 16'h3333, 32'h44444444);
    pc  = mk(2'b01, 8'h55, 16'hAAAA, 16'hBBBB, 16'hCCCC, 32'h12345678);
    pm  = mk(2'b10, 8'h77, 16'h7777, 16'h7777, 16'h7777, 32'h77777777);
    pcl = mk(2'b11, 8'h99, 16'h9999, 16'h9999, 16'h9999, 32'h99999999);

    //          req    pkt  pop   ack   drop  cnt  head
    tbl[0]  = '{1'b1, pa,  1'b0, 1'b1, 1'b0, 1, to_svc(pa)};
    tbl[1]  = '{1'b0, pa,  1'b0, 1'b0, 1'b0, 1, to_svc(pa)};
    tbl[2]  = '{1'b0, pa,  1'b1, 1'b0, 1'b0, 0, to_svc(pa)};
    tbl[3]  = '{1'b0, pa,  1'b1, 1'b0, 1'b0, 0, to_svc(pa)};
    tbl[4]  = '{1'b1, pm,  1'b0, 1'b1, 1'b1, 0, to_svc(pa)};
    tbl[5]  = '{1'b0, pm,  1'b0, 1'b0, 1'b0, 0, to_svc(pa)};
    tbl[6]  = '{1'b1, pcl, 1'b0, 1'b1, 1'b1, 0, to_svc(pa)};
    tbl[7]  = '{1'b0, pcl, 1'b0, 1'b0, 1'b0, 0, to_svc(pa)};
    tbl[8]  = '{1'b1, pb,  1'b0, 1'b1, 1'b0, 1, to_svc(pb)};
    tbl[9]  = '{1'b1, pc,  1'b0, 1'b0, 1'b0, 1, to_svc(pb)};
    tbl[10] = '{1'b1, pc,  1'b0, 1'b1, 1'b0, 2, to_svc(pb)};
    tbl[11] = '{1'b0, pc,  1'b1, 1'b0, 1'b0, 1, to_svc(pc)};

    // Reset state
    do_reset();
    chk("rst_count", 96'(br_svc_count_o), 96'(0));
    chk("rst_rx", 96'(br_svc_rx_o), 96'(0));
    chk("rst_ack", 96'(br_ack_o), 96'(0));
    chk("rst_drop", 96'(br_mon_drop_o), 96'(0));

    // Directed table
    for (int i = 0; i < 12; i++) begin
      br_req_i     = tbl[i].req;
      br_data_i    = tbl[i].pkt;
      br_svc_ack_i = tbl[i].pop;
      tick();
      chk($sformatf("tbl%0d_ack", i), 96'(br_ack_o), 96'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_drop", i), 96'(br_mon_drop_o), 96'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_cnt", i), 96'(br_svc_count_o), 96'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_rx", i), 96'(br_svc_rx_o), 96'(tbl[i].e_cnt != 0));
      if (tbl[i].e_cnt != 0)
        chk($sformatf("tbl%0d_data", i), 96'(br_svc_data_o), 96'(tbl[i].e_data));
    end
    br_req_i = 1'b0;
    br_svc_ack_i = 1'b0;

    // Full queue holds the 9th request until a pop frees a slot; no bypass on the pop edge
    do_reset();
    for (int i = 0; i < 9; i++)
      p9[i] = mk(2'b01, 8'(i + 1), 16'(i), 16'h0, 16'(100 + i), 32'(i + 1));
    br_req_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      br_data_i = p9[i];
      tick();
      chk($sformatf("full_ack%0d", i), 96'(br_ack_o), 96'(1'b1));
      br_data_i = p9[i + 1];
      tick();
    end
    chk("full_cnt8", 96'(br_svc_count_o), 96'(8));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_hold_ack", 96'(br_ack_o), 96'(1'b0));
      chk("full_hold_cnt", 96'(br_svc_count_o), 96'(8));
    end
    br_svc_ack_i = 1'b1;
    tick();
    br_svc_ack_i = 1'b0;
    chk("full_pop_nobypass", 96'(br_ack_o), 96'(1'b0));
    chk("full_pop_cnt7", 96'(br_svc_count_o), 96'(7));
    tick();
    chk("full_ninth_ack", 96'(br_ack_o), 96'(1'b1));
    chk("full_ninth_cnt", 96'(br_svc_count_o), 96'(8));
    br_req_i = 1'b0;
    for (int i = 1; i < 9; i++)
      pop_chk($sformatf("drain%0d", i), to_svc(p9[i]));
    chk("drain_cnt0", 96'(br_svc_count_o), 96'(0));
    chk("drain_rx0", 96'(br_svc_rx_o), 96'(0));

    // Simultaneous push and pop at count 3
    do_reset();
    push(pa); push(pb); push(pc);
    chk("sim_cnt3", 96'(br_svc_count_o), 96'(3));
    br_req_i = 1'b1;
    br_data_i = pm;
    br_data_i.service = 2'b00;
    br_svc_ack_i = 1'b1;
    tick();
    br_req_i = 1'b0;
    br_svc_ack_i = 1'b0;
    chk("sim_ack", 96'(br_ack_o), 96'(1'b1));
    chk("sim_cnt", 96'(br_svc_count_o), 96'(3));
    chk("sim_head", 96'(br_svc_data_o), 96'(to_svc(pb)));

    // Pointer wrap over 20 entries
    do_reset();
    for (int i = 0; i < 20; i++)
      pw[i] = mk(2'(i % 2), 8'(i), 16'(i * 3), 16'h0, 16'(i * 5), 32'(32'hC0DE0000 + i));
    for (int i = 0; i < 20; i++) begin
      push(pw[i]);
      pop_chk($sformatf("wrap%0d", i), to_svc(pw[i]));
    end
    chk("wrap_cnt0", 96'(br_svc_count_o), 96'(0));

    // Reset mid-handshake with 5 entries, then a still-high request is taken fresh
    do_reset();
    for (int i = 0; i < 4; i++) push(pw[i]);
    br_req_i = 1'b1;
    br_data_i = pw[4];
    tick();
    chk("mid_ack_pre", 96'(br_ack_o), 96'(1'b1));
    chk("mid_cnt_pre", 96'(br_svc_count_o), 96'(5));
    br_data_i = pc;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_cnt", 96'(br_svc_count_o), 96'(0));
    chk("mid_rst_rx", 96'(br_svc_rx_o), 96'(0));
    chk("mid_rst_ack", 96'(br_ack_o), 96'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("mid_fresh_ack", 96'(br_ack_o), 96'(1'b1));
    chk("mid_fresh_cnt", 96'(br_svc_count_o), 96'(1));
    chk("mid_fresh_data", 96'(br_svc_data_o), 96'(to_svc(pc)));
    br_req_i = 1'b0;
    tick();

    // Random traffic against a queue model
    do_reset();
    mq.delete();
    m_ack = 1'b0;
    m_drop = 1'b0;
    r_req = 1'b0;
    r_pkt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_ack || !r_req) begin
        r_req = ($urandom_range(0, 2) != 0);
        r_pkt = rnd_pkt();
      end
      br_req_i = r_req;
      br_data_i = r_pkt;
      if (((cyc / 250) % 2) == 0) br_svc_ack_i = ($urandom_range(0, 3) == 0);
      else                        br_svc_ack_i = ($urandom_range(0, 3) != 0);

      acc = r_req && !m_ack && (r_pkt.service[1] || (mq.size() < DEPTH));
      pp  = br_svc_ack_i && (mq.size() != 0);
      if (pp) void'(mq.pop_front());
      if (acc && !r_pkt.service[1]) mq.push_back(to_svc(r_pkt));
      m_ack  = acc;
      m_drop = acc && r_pkt.service[1];

      tick();
      chk("rnd_ack", 96'(br_ack_o), 96'(m_ack));
      chk("rnd_drop", 96'(br_mon_drop_o), 96'(m_drop));
      chk("rnd_cnt", 96'(br_svc_count_o), 96'(mq.size()));
      chk("rnd_rx", 96'(br_svc_rx_o), 96'(mq.size() != 0));
      if (mq.size() != 0)
        chk("rnd_data", 96'(br_svc_data_o), 96'(mq[0]));
    end
    br_req_i = 1'b0;
    br_svc_ack_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/br_svc_fifo.md
BR_SVC_FIFO -- requirements
Module: br_svc_fifo

Interface
REQ-001 SHALL have parameter BR_SVC_DEPTH, default 8: number of queued service entries; power of two, >= 2.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port br_req_i, input, 1: BrLite router has a delivered packet, level until acked.
REQ-005 SHALL have port br_ack_o, input-side handshake output, 1: one-cycle accept/consume pulse to router.
REQ-006 SHALL have port br_data_i, input, brlite_out_t: incoming packet (service[1:0], ksvc[7:0], seq_source/seq_target[15:0], producer[15:0], payload[31:0]).
REQ-007 SHALL have port br_svc_rx_o, output, 1: queue non-empty; head entry valid.
REQ-008 SHALL have port br_svc_ack_i, input, 1: pop pulse from NI (one cycle per pop).
REQ-009 SHALL have port br_svc_data_o, output, brlite_svc_t: head entry (ksvc, seq_source, producer, payload).
REQ-010 SHALL have port br_svc_count_o, output, $clog2(BR_SVC_DEPTH)+1: current occupancy.
REQ-011 SHALL have port br_mon_drop_o, output, 1: one-cycle pulse when a monitor/clear packet is consumed without storing.

Function
REQ-012 SHALL classify br_data_i.service: 2'b00 (ALL) and 2'b01 (TARGET) are storable; 2'b10 (MONITOR) and 2'b11 (CLEAR) are non-storable.
REQ-013 SHALL accept a packet on an edge where br_req_i=1, br_ack_o=0 and (packet non-storable or count < BR_SVC_DEPTH).
REQ-014 SHALL, on accept, drive br_ack_o=1 for exactly the following cycle, then 0; no accept is evaluated while br_ack_o=1.
REQ-015 SHALL, on accept of a storable packet, write {ksvc, seq_source, producer, payload} at the write pointer and increment the write pointer and count on the same edge.
REQ-016 SHALL, on accept of a non-storable packet, leave the queue unchanged and pulse br_mon_drop_o for one cycle, coincident with br_ack_o.
REQ-017 SHALL hold br_ack_o=0 while full and the packet is storable; br_req_i stays pending with no data loss.
REQ-018 SHALL pop on an edge where br_svc_ack_i=1 and count > 0: increment the read pointer and decrement count.
REQ-019 SHALL ignore br_svc_ack_i when count = 0; no pointer or count change, no error flag.
REQ-020 SHALL, on simultaneous push and pop, update both pointers and leave count unchanged.
REQ-021 SHALL evaluate fullness from registered count before the edge; pop and push on the same edge when full do not admit the push (no bypass); push is admitted next evaluation.
REQ-022 SHALL wrap pointers modulo BR_SVC_DEPTH.
REQ-023 SHALL drive br_svc_rx_o = (count != 0) and br_svc_data_o = entry at read pointer, both combinationally from registered state.
REQ-024 SHALL make a pushed entry visible on br_svc_rx_o/br_svc_data_o in the cycle after the accepting edge (one-cycle latency).
REQ-025 SHALL, for br_svc_data_o with count = 0, hold the last storage contents; value is don't-care to consumers.
REQ-026 SHALL hold br_svc_data_o stable while br_svc_rx_o=1 and no pop occurs, regardless of pushes.

Reset
REQ-027 SHALL, on rst_ni=0, asynchronously clear read/write pointers, count, br_ack_o, br_mon_drop_o; br_svc_rx_o=0, br_svc_count_o=0.
REQ-028 SHALL not reset storage contents; br_svc_data_o is don't-care after reset until first push.
REQ-029 SHALL discard any packet in progress when reset asserts mid-handshake; a br_req_i still high after release is treated as a new packet.

Verification
REQ-030 SHALL be covered by: push one packet {service=01, ksvc=8'h2A, seq_source=16'h0102, producer=16'h0304, payload=32'hDEADBEEF} -> br_ack_o one cycle, next cycle br_svc_rx_o=1, br_svc_data_o matches, count=1; pulse br_svc_ack_i -> rx_o=0, count=0.
REQ-031 SHALL be covered by: 9 back-to-back storable packets, depth 8, no pops -> 8 acks, count=8, 9th br_req_i held unacked; one pop -> 9th acked within 2 cycles, FIFO order 1..9 on drain.
REQ-032 SHALL be covered by: service=2'b10 packet with empty queue -> br_ack_o and br_mon_drop_o pulse together, count stays 0, rx_o stays 0.
REQ-033 SHALL be covered by: count=3, push and pop on same edge -> count stays 3; pop with count=0 -> no change; 20 pushes/pops -> pointer wrap, order preserved.
REQ-034 SHALL be covered by: rst_ni low mid-stream with count=5 and br_ack_o=1 -> immediately count=0, rx_o=0, ack_o=0; br_req_i high after release -> accepted as fresh packet.
